fetch_sequencer: RTL and testbench

Controls the instruction-fetch stage. Owns the fetch PC and runs a request/ready handshake with a variable-latency instruction memory. Presents one buffered instruction {PC, PC+4, word} with a valid flag to the IF/ID boundary. Handles downstream stalls through a one-entry skid buffer. Handles branch/jump redirects from EX by flushing and, when needed, dropping an in-flight fetch.

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, handshakes with a variable-latency
// instruction memory and presents one registered instruction (with a one-entry skid) to IF/ID.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  input  logic              IMEM_READY,
  input  logic [31:0]       IMEM_RDATA,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic              IF_VALID,
  output logic [ADDR_W-1:0] IF_PC,
  output logic [ADDR_W-1:0] IF_PC_PLUS4,
  output logic [31:0]       IF_INSTRUCTION
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Sequential increment wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_p0, pc_n;
  logic [ADDR_W-1:0]   drop_addr_p0, drop_addr_n;

  logic                vld_p1, vld_n;
  logic [ADDR_W-1:0]   out_pc_p1, out_pc_n;
  logic [ADDR_W-1:0]   out_pc4_p1, out_pc4_n;
  logic [DATA_W-1:0]   out_instr_p1, out_instr_n;

  logic [ADDR_W-1:0]   skid_pc_p1;
  logic [DATA_W-1:0]   skid_instr_p1;
  logic                skid_load;

  logic                consume;
  logic                slot_free;

  assign consume   = vld_p1 & ~STALL;
  assign slot_free = ~vld_p1 | ~STALL;

  // p0: request side; DROP keeps presenting the abandoned address until the memory answers.
  assign IMEM_REQ  = ~RST & (state != S_HOLD);
  assign IMEM_ADDR = (state == S_DROP) ? drop_addr_p0 : pc_p0;

  always_comb begin
    state_n     = state;
    pc_n        = pc_p0;
    drop_addr_n = drop_addr_p0;
    vld_n       = vld_p1;
    out_pc_n    = out_pc_p1;
    out_pc4_n   = out_pc4_p1;
    out_instr_n = out_instr_p1;
    skid_load   = 1'b0;

    if (consume) begin
      vld_n = 1'b0;
    end

    if (REDIRECT) begin
      // Redirect flushes everything; an unanswered request must still complete in DROP.
      vld_n = 1'b0;
      pc_n  = word_align(REDIRECT_PC);
      case (state)
        S_REQ: begin
          if (!IMEM_READY) begin
            state_n     = S_DROP;
            drop_addr_n = pc_p0;
          end
        end
        S_HOLD:  state_n = S_REQ;
        S_DROP:  if (IMEM_READY) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (IMEM_READY) begin
            pc_n = pc_inc(pc_p0);
            if (slot_free) begin
              vld_n       = 1'b1;
              out_pc_n    = pc_p0;
              out_pc4_n   = pc_inc(pc_p0);
              out_instr_n = IMEM_RDATA;
            end else begin
              skid_load = 1'b1;
              state_n   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            vld_n       = 1'b1;
            out_pc_n    = skid_pc_p1;
            out_pc4_n   = pc_inc(skid_pc_p1);
            out_instr_n = skid_instr_p1;
            state_n     = S_REQ;
          end
        end
        S_DROP:  if (IMEM_READY) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_REQ;
      pc_p0        <= RESET_PC;
      drop_addr_p0 <= RESET_PC;
      vld_p1       <= 1'b0;
      out_pc_p1    <= '0;
      out_pc4_p1   <= '0;
      out_instr_p1 <= '0;
    end else begin
      state        <= state_n;
      pc_p0        <= pc_n;
      drop_addr_p0 <= drop_addr_n;
      vld_p1       <= vld_n;
      out_pc_p1    <= out_pc_n;
      out_pc4_p1   <= out_pc4_n;
      out_instr_p1 <= out_instr_n;
    end
  end

  // p1: skid entry; its occupancy is implied by the HOLD state.
  always_ff @(posedge CLK) begin
    if (skid_load) begin
      skid_pc_p1    <= pc_p0;
      skid_instr_p1 <= IMEM_RDATA;
    end
  end

  assign IF_VALID       = vld_p1;
  assign IF_PC          = out_pc_p1;
  assign IF_PC_PLUS4    = out_pc4_p1;
  assign IF_INSTRUCTION = out_instr_p1;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: in-order scoreboard model plus directed scenarios
// (zero-wait, slow memory, stall/skid, redirects, PC wrap, mid-run reset).
module tb_fetch_sequencer;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // DUT 1: RESET_PC = 0, bench-controlled memory latency
  logic        rst1, stall, redirect;
  logic [31:0] redirect_pc;
  logic        ready1;
  logic [31:0] rdata1;
  logic        req1, vld1;
  logic [31:0] addr1, pc1, pc4_1, instr1;

  int   lat;
  logic force_low;
  int   wait_cnt;

  assign ready1 = req1 && (wait_cnt >= lat) && !force_low;
  assign rdata1 = ready1 ? (addr1 ^ K) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst1)                 wait_cnt <= 0;
    else if (req1 && ready1)  wait_cnt <= 0;
    else if (req1)            wait_cnt <= wait_cnt + 1;
  end

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut1 (
    .CLK(clk), .RST(rst1), .STALL(stall), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .IMEM_READY(ready1), .IMEM_RDATA(rdata1), .IMEM_REQ(req1), .IMEM_ADDR(addr1),
    .IF_VALID(vld1), .IF_PC(pc1), .IF_PC_PLUS4(pc4_1), .IF_INSTRUCTION(instr1)
  );

  // DUT 2: RESET_PC near the top of the address space, READY tied high
  logic        rst2;
  logic        req2, vld2;
  logic [31:0] addr2, pc2, pc4_2, instr2, rdata2;
  assign rdata2 = addr2 ^ K;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(clk), .RST(rst2), .STALL(1'b0), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .IMEM_READY(1'b1), .IMEM_RDATA(rdata2), .IMEM_REQ(req2), .IMEM_ADDR(addr2),
    .IF_VALID(vld2), .IF_PC(pc2), .IF_PC_PLUS4(pc4_2), .IF_INSTRUCTION(instr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: instructions must be consumed in strict address order, restarting at each
  // aligned redirect target; a waiting request must hold its address; after a redirect
  // the output is empty, and with no fetch outstanding the next request is the target.
  logic [31:0] exp_pc;
  logic        pend, chk_inv, chk_tgt;
  logic [31:0] pend_addr, tgt_q;

  always @(negedge clk) begin
    if (rst1) begin
      exp_pc  = 32'h0;
      pend    = 1'b0;
      chk_inv = 1'b0;
      chk_tgt = 1'b0;
    end else begin
      if (pend) begin
        chk("held_req", {31'b0, req1}, 32'd1);
        chk("held_addr", addr1, pend_addr);
      end
      if (chk_inv) chk("flush_valid", {31'b0, vld1}, 32'd0);
      if (chk_tgt) begin
        chk("tgt_req", {31'b0, req1}, 32'd1);
        chk("tgt_addr", addr1, tgt_q);
      end
      if (vld1 && !stall) begin
        chk("seq_pc", pc1, exp_pc);
        chk("seq_pc4", pc4_1, exp_pc + 32'd4);
        chk("seq_instr", instr1, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
      end
      pend      = req1 && !ready1;
      pend_addr = addr1;
      chk_inv   = redirect;
      chk_tgt   = redirect && (!req1 || ready1);
      tgt_q     = redirect_pc & 32'hFFFF_FFFC;
      if (redirect) exp_pc = tgt_q;
    end
  end

  int cyc;

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) next_cycle();
  endtask

  // Leaves the bench at the start of cycle 1 after reset release.
  task automatic reset1();
    rst1 = 1'b1;
    next_cycle();
    rst1 = 1'b0;
    cyc = 1;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    lat = 0; force_low = 1'b0; cyc = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_valid", {31'b0, vld1}, 32'd0);
    chk("rst_req", {31'b0, req1}, 32'd0);
    chk("rst_pc", pc1, 32'h0);
    chk("rst_pc4", pc4_1, 32'h0);
    chk("rst_instr", instr1, 32'h0);
    chk("rst2_pc4", pc4_2, 32'h0);

    // Zero-wait memory
    reset1();
    @(negedge clk);
    chk("zw_c1_valid", {31'b0, vld1}, 32'd0);
    chk("zw_c1_addr", addr1, 32'h0);
    to_cycle(2);
    @(negedge clk);
    chk("zw_c2_valid", {31'b0, vld1}, 32'd1);
    chk("zw_c2_pc", pc1, 32'h0);
    chk("zw_c2_addr", addr1, 32'h4);
    to_cycle(10);
    @(negedge clk);
    chk("zw_c10_pc", pc1, 32'h20);

    // Slow memory: READY on every third cycle of a request
    lat = 2;
    reset1();
    to_cycle(2);
    @(negedge clk);
    chk("slow_c2_valid", {31'b0, vld1}, 32'd0);
    chk("slow_c2_addr", addr1, 32'h0);
    to_cycle(4);
    @(negedge clk);
    chk("slow_c4_pc", pc1, 32'h0);
    chk("slow_c4_valid", {31'b0, vld1}, 32'd1);
    to_cycle(5);
    @(negedge clk);
    chk("slow_c5_valid", {31'b0, vld1}, 32'd0);
    to_cycle(7);
    @(negedge clk);
    chk("slow_c7_pc", pc1, 32'h4);
    to_cycle(19);

    // Stall with IF_PC=8: fetch of 12 goes to the skid
    lat = 0;
    reset1();
    to_cycle(4);
    stall = 1'b1;
    @(negedge clk);
    chk("stall_c4_pc", pc1, 32'h8);
    to_cycle(6);
    @(negedge clk);
    chk("hold_req", {31'b0, req1}, 32'd0);
    chk("hold_pc", pc1, 32'h8);
    to_cycle(8);
    stall = 1'b0;
    to_cycle(9);
    @(negedge clk);
    chk("skid_pc", pc1, 32'hC);
    chk("skid_instr", instr1, 32'hC ^ K);
    chk("resume_addr", addr1, 32'h10);
    to_cycle(10);
    @(negedge clk);
    chk("resume_pc", pc1, 32'h10);
    to_cycle(14);

    // Redirect while the request to 0x20 is still waiting
    reset1();
    to_cycle(9);
    force_low = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("drop_pre_addr", addr1, 32'h20);
    to_cycle(10);
    redirect = 1'b0;
    @(negedge clk);
    chk("drop_valid", {31'b0, vld1}, 32'd0);
    chk("drop_addr", addr1, 32'h20);
    to_cycle(12);
    force_low = 1'b0;
    to_cycle(13);
    @(negedge clk);
    chk("drop_next_addr", addr1, 32'h100);
    chk("drop_next_valid", {31'b0, vld1}, 32'd0);
    to_cycle(14);
    @(negedge clk);
    chk("drop_first_pc", pc1, 32'h100);
    chk("drop_first_instr", instr1, 32'h100 ^ K);
    to_cycle(18);

    // Redirect coincident with READY and STALL
    reset1();
    to_cycle(3);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    to_cycle(4);
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("rdy_redir_valid", {31'b0, vld1}, 32'd0);
    chk("rdy_redir_addr", addr1, 32'h40);
    to_cycle(5);
    @(negedge clk);
    chk("rdy_redir_pc", pc1, 32'h40);
    to_cycle(8);

    // Redirect from HOLD discards both the presented and the skid instruction
    reset1();
    to_cycle(3);
    stall = 1'b1;
    to_cycle(4);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0082;
    @(negedge clk);
    chk("hold_redir_req", {31'b0, req1}, 32'd0);
    to_cycle(5);
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("hold_redir_addr", addr1, 32'h80);
    to_cycle(6);
    @(negedge clk);
    chk("hold_redir_pc", pc1, 32'h80);
    to_cycle(9);
    rst1 = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, vld1}, 32'd0);
    chk("midrst_req", {31'b0, req1}, 32'd0);

    // PC wrap at the top of the address space
    next_cycle();
    rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_c1_addr", addr2, 32'hFFFF_FFF8);
    next_cycle();
    @(negedge clk);
    chk("wrap_c2_pc", pc2, 32'hFFFF_FFF8);
    chk("wrap_c2_pc4", pc4_2, 32'hFFFF_FFFC);
    chk("wrap_c2_instr", instr2, 32'hFFFF_FFF8 ^ K);
    next_cycle();
    @(negedge clk);
    chk("wrap_c3_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_c3_pc4", pc4_2, 32'h0);
    chk("wrap_c3_addr", addr2, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wrap_c4_pc", pc2, 32'h0);
    chk("wrap_c4_pc4", pc4_2, 32'h4);
    chk("wrap_c4_instr", instr2, K);
    next_cycle();
    rst2 = 1'b1;
    #1;
    chk("rst2_valid", {31'b0, vld2}, 32'd0);
    chk("rst2_req", {31'b0, req2}, 32'd0);
    chk("rst2_pc", pc2, 32'h0);
    chk("rst2_pc4b", pc4_2, 32'h0);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
